pwm_servo_multi: RTL and testbench



---
 rtl/pwm_servo_multi_if.sv | 35 +++
 rtl/pwm_servo_multi.sv | 178 +++++++++++++++++
 tb/tb_pwm_servo_multi.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pwm_servo_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_servo_multi_if
// Purpose  : Control/status bundle for the multi-channel servo pulse
//            generator: enable, per-channel mode and trim push inputs in,
//            pulse outputs, frame strobe, ramp flags and trim readback out.
// Revision : 1.0 - initial release
// ============================================================================
interface pwm_servo_multi_if #(
  parameter int CH = 2,
  parameter int TW = 16
);
  logic              enable;
  logic [2*CH-1:0]   mode;
  logic [CH-1:0]     trim_up;
  logic [CH-1:0]     trim_dn;
  logic [CH-1:0]     trim_clr;
  logic [CH-1:0]     pwm_out;
  logic              frame_start;
  logic [CH-1:0]     ramping;
  logic [CH*TW-1:0]  trim_val;

  // Controller side: drives the requests, observes the outputs.
  modport master (
    output enable, mode, trim_up, trim_dn, trim_clr,
    input  pwm_out, frame_start, ramping, trim_val
  );

  // Pulse generator side.
  modport slave (
    input  enable, mode, trim_up, trim_dn, trim_clr,
    output pwm_out, frame_start, ramping, trim_val
  );
endinterface
`default_nettype wire

// File: rtl/pwm_servo_multi.sv
`default_nettype none
// ============================================================================
// Module   : pwm_servo_multi
// Purpose  : CH-channel servo/ESC pulse generator sharing one frame counter.
//            Each channel picks stop/forward/reverse, carries a saturating
//            signed trim, and slews its pulse width by at most RAMP_STEP per
//            frame. Widths only change on the frame boundary, so every
//            emitted pulse is a complete, glitch-free pulse.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_servo_multi #(
  parameter int CH        = 2,
  parameter int CW        = 20,
  parameter int TW        = 16,
  parameter int PERIOD    = 500000,
  parameter int NEUTRAL   = 75260,
  parameter int SPAN      = 5000,
  parameter int TRIM_STEP = 100,
  parameter int TRIM_MAX  = 20000,
  parameter int RAMP_STEP = 250
) (
  input  wire logic        m_clock,
  input  wire logic        p_reset,
  pwm_servo_multi_if.slave bus
);

  // --------------------------------------------------------------------------
  // Elaboration-time sanity checks on the parameter set
  // --------------------------------------------------------------------------
  if ((PERIOD < 2) || ((PERIOD - 1) >= (1 << CW))) begin : g_bad_period
    $error("pwm_servo_multi: PERIOD-1 must fit in CW bits");
  end
  if ((NEUTRAL - SPAN - TRIM_MAX) < 1) begin : g_bad_low
    $error("pwm_servo_multi: NEUTRAL-SPAN-TRIM_MAX must be >= 1");
  end
  if ((NEUTRAL + SPAN + TRIM_MAX) > (PERIOD - 1)) begin : g_bad_high
    $error("pwm_servo_multi: NEUTRAL+SPAN+TRIM_MAX must be <= PERIOD-1");
  end
  if ((CW + 2) <= TW) begin : g_bad_tw
    $error("pwm_servo_multi: TW must be narrower than CW+2");
  end

  // --------------------------------------------------------------------------
  // Constants in the widths they are used at
  // --------------------------------------------------------------------------
  localparam logic [CW-1:0]        LAST      = CW'(PERIOD - 1);
  localparam logic [CW-1:0]        NEUTRAL_W = CW'(NEUTRAL);
  localparam logic [CW-1:0]        RAMP_W    = CW'(RAMP_STEP);
  localparam logic signed [CW+1:0] NEUTRAL_S = (CW+2)'(NEUTRAL);
  localparam logic signed [CW+1:0] SPAN_S    = (CW+2)'(SPAN);
  localparam logic signed [CW+1:0] RAMP_S    = (CW+2)'(RAMP_STEP);
  localparam logic signed [TW:0]   TSTEP_S   = (TW+1)'(TRIM_STEP);
  localparam logic signed [TW:0]   TMAX_S    = (TW+1)'(TRIM_MAX);
  localparam logic signed [TW:0]   TMIN_S    = -TMAX_S;

  // --------------------------------------------------------------------------
  // Shared frame timing
  // --------------------------------------------------------------------------
  logic [CW-1:0]    count;
  logic             en_q;
  logic             frame_start;
  logic             bnd;
  logic [CH-1:0]    pwm_vec;
  logic [CH-1:0]    ramp_vec;
  logic [CH*TW-1:0] trim_vec;

  // Last cycle of the frame: the only instant channel state may change.
  assign bnd = (count == LAST);

  // Frame counter, frame-sampled enable and the frame strobe. The strobe is
  // registered from count==0 so it lines up with the registered pulses.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      count       <= '0;
      en_q        <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      count       <= bnd ? '0 : count + CW'(1);
      frame_start <= (count == '0);
      if (bnd) begin
        en_q <= bus.enable;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel trim, target, slew and pulse generation
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [1:0]             ch_mode;
    logic signed [TW-1:0]   trim;
    logic signed [TW-1:0]   trim_next;
    logic signed [TW:0]     trim_up_v;
    logic signed [TW:0]     trim_dn_v;
    logic [CW-1:0]          width;
    logic [CW-1:0]          width_ramp;
    logic signed [CW+1:0]   offset;
    logic signed [CW+1:0]   target;
    logic signed [CW+1:0]   width_s;
    logic signed [CW+1:0]   diff;
    logic                   pwm;

    assign ch_mode = bus.mode[2*i +: 2];

    // Target width, slew-limited candidate width and next trim value.
    always_comb begin
      offset     = '0;
      target     = '0;
      width_s    = '0;
      diff       = '0;
      width_ramp = width;
      trim_up_v  = '0;
      trim_dn_v  = '0;
      trim_next  = trim;

      case (ch_mode)
        2'b01:   offset = SPAN_S;
        2'b10:   offset = -SPAN_S;
        default: offset = '0;
      endcase

      // Operands are sized so NEUTRAL +/- SPAN +/- TRIM_MAX cannot overflow.
      target  = NEUTRAL_S + offset + {{(CW+2-TW){trim[TW-1]}}, trim};
      width_s = $signed({2'b00, width});
      diff    = target - width_s;

      if (diff > RAMP_S) begin
        width_ramp = width + RAMP_W;
      end else if (diff < -RAMP_S) begin
        width_ramp = width - RAMP_W;
      end else begin
        width_ramp = target[CW-1:0];
      end

      // One extra bit of headroom lets the saturation compare see overflow.
      trim_up_v = {trim[TW-1], trim} + TSTEP_S;
      trim_dn_v = {trim[TW-1], trim} - TSTEP_S;

      if (bus.trim_clr[i]) begin
        trim_next = '0;
      end else if (bus.trim_up[i] && bus.trim_dn[i]) begin
        trim_next = trim;
      end else if (bus.trim_up[i]) begin
        trim_next = (trim_up_v > TMAX_S) ? TMAX_S[TW-1:0] : trim_up_v[TW-1:0];
      end else if (bus.trim_dn[i]) begin
        trim_next = (trim_dn_v < TMIN_S) ? TMIN_S[TW-1:0] : trim_dn_v[TW-1:0];
      end
    end

    // Channel state updates on the boundary; the pulse is compared every
    // cycle. A disabled channel jumps straight to target so re-enabling
    // starts from the commanded width without a ramp.
    always_ff @(posedge m_clock or negedge p_reset) begin
      if (!p_reset) begin
        trim  <= '0;
        width <= NEUTRAL_W;
        pwm   <= 1'b0;
      end else begin
        pwm <= en_q & (count < width);
        if (bnd) begin
          trim  <= trim_next;
          width <= en_q ? width_ramp : target[CW-1:0];
        end
      end
    end

    assign pwm_vec[i]            = pwm;
    assign ramp_vec[i]           = (width_s != target);
    assign trim_vec[i*TW +: TW]  = trim;
  end

  assign bus.pwm_out     = pwm_vec;
  assign bus.frame_start = frame_start;
  assign bus.ramping     = ramp_vec;
  assign bus.trim_val    = trim_vec;

endmodule
`default_nettype wire

// File: tb/tb_pwm_servo_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_servo_multi
// Purpose  : Directed, self-checking bench for pwm_servo_multi using a short
//            frame (PERIOD=100). Each frame is measured from frame_start and
//            compared against hand-derived pulse widths, trim and ramp flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_servo_multi;

  localparam int CH        = 2;
  localparam int CW        = 20;
  localparam int TW        = 16;
  localparam int PERIOD    = 100;
  localparam int NEUTRAL   = 50;
  localparam int SPAN      = 20;
  localparam int TRIM_STEP = 2;
  localparam int TRIM_MAX  = 10;
  localparam int RAMP_STEP = 5;

  logic m_clock = 1'b0;
  logic p_reset = 1'b0;

  int errors = 0;
  int checks = 0;

  pwm_servo_multi_if #(.CH(CH), .TW(TW)) bus ();

  pwm_servo_multi #(
    .CH(CH), .CW(CW), .TW(TW), .PERIOD(PERIOD), .NEUTRAL(NEUTRAL),
    .SPAN(SPAN), .TRIM_STEP(TRIM_STEP), .TRIM_MAX(TRIM_MAX),
    .RAMP_STEP(RAMP_STEP)
  ) dut (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .bus     (bus)
  );

  // 10-unit clock
  always #5 m_clock = ~m_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  function automatic logic [31:0] trim_of(input int ch);
    logic [TW-1:0] t;
    t = bus.trim_val[ch*TW +: TW];
    return 32'($signed(t));
  endfunction

  // Measure one frame starting at the next frame_start. act_id: 1 drops
  // enable at count 20; 2 glitches ch1 mode mid-frame and restores it.
  task automatic run_frame(input string tag, input int ew0, input int ew1,
                           input int etv0, input int er0, input int act_id);
    int   waits;
    int   hi0;
    int   hi1;
    int   bad;
    logic low0;
    logic low1;
    waits = 0; hi0 = 0; hi1 = 0; bad = 0; low0 = 1'b0; low1 = 1'b0;
    @(negedge m_clock);
    while (bus.frame_start !== 1'b1 && waits < 300) begin
      waits++;
      @(negedge m_clock);
    end
    check({tag, ".fs_wait"}, waits, 0);
    check({tag, ".trim0"}, trim_of(0), etv0);
    check({tag, ".ramp0"}, 32'(bus.ramping[0]), er0);
    for (int k = 0; k < PERIOD; k++) begin
      if (k > 0) @(negedge m_clock);
      if (bus.pwm_out[0] === 1'b1) begin
        if (low0) bad++;
        hi0++;
      end else begin
        low0 = 1'b1;
      end
      if (bus.pwm_out[1] === 1'b1) begin
        if (low1) bad++;
        hi1++;
      end else begin
        low1 = 1'b1;
      end
      if (k > 0 && bus.frame_start !== 1'b0) bad++;
      if (act_id == 1 && k == 19) bus.enable = 1'b0;
      if (act_id == 2 && k == 40) bus.mode[3:2] = 2'b01;
      if (act_id == 2 && k == 50) bus.mode[3:2] = 2'b00;
    end
    check({tag, ".w0"}, hi0, ew0);
    check({tag, ".w1"}, hi1, ew1);
    check({tag, ".shape"}, bad, 0);
  endtask

  // Expected tables for the ramp/trim sequences
  int s2_w [5]  = '{50, 55, 60, 65, 70};
  int s2_r [5]  = '{1, 1, 1, 1, 0};
  int s3_w [8]  = '{70, 65, 60, 55, 56, 58, 60, 60};
  int s3_t [8]  = '{0, 2, 4, 6, 8, 10, 10, 10};
  int s3_r [8]  = '{1, 1, 1, 1, 1, 1, 0, 0};
  int s4_w [7]  = '{60, 55, 50, 46, 44, 42, 40};
  int s4_t [7]  = '{0, -2, -4, -6, -8, -10, -10};
  int s4_r [7]  = '{1, 1, 1, 1, 1, 1, 0};

  initial begin
    int waits;
    bus.enable   = 1'b0;
    bus.mode     = '0;
    bus.trim_up  = '0;
    bus.trim_dn  = '0;
    bus.trim_clr = '0;

    // Reset state
    repeat (3) @(negedge m_clock);
    check("rst.pwm", 32'(bus.pwm_out), 0);
    check("rst.fs", 32'(bus.frame_start), 0);
    check("rst.ramp", 32'(bus.ramping), 0);
    check("rst.trim", 32'(bus.trim_val), 0);

    // Scenario 1: first frame dark, then 50-cycle stop pulses
    p_reset    = 1'b1;
    bus.enable = 1'b1;
    run_frame("s1.f0", 0, 0, 0, 0, 0);
    run_frame("s1.f1", 50, 50, 0, 0, 0);

    // Scenario 2: ch0 forward, slewing 50 -> 70
    bus.mode = 4'b0001;
    for (int f = 0; f < 5; f++)
      run_frame($sformatf("s2.f%0d", f), s2_w[f], 50, 0, s2_r[f], 0);

    // Scenario 3: back to stop with trim_up held for 7 boundaries
    bus.mode    = 4'b0000;
    bus.trim_up = 2'b01;
    for (int f = 0; f < 7; f++)
      run_frame($sformatf("s3.f%0d", f), s3_w[f], 50, s3_t[f], s3_r[f], 0);
    bus.trim_up = 2'b00;
    run_frame("s3.f7", s3_w[7], 50, s3_t[7], s3_r[7], 0);

    // Scenario 4: up&dn holds, clr beats up, dn saturates at -TRIM_MAX
    bus.trim_up = 2'b01;
    bus.trim_dn = 2'b01;
    run_frame("s4.both0", 60, 50, 10, 0, 0);
    run_frame("s4.both1", 60, 50, 10, 0, 0);
    bus.trim_dn  = 2'b00;
    bus.trim_clr = 2'b01;
    run_frame("s4.clr", 60, 50, 10, 0, 0);
    bus.trim_clr = 2'b00;
    bus.trim_up  = 2'b00;
    bus.trim_dn  = 2'b01;
    for (int f = 0; f < 7; f++)
      run_frame($sformatf("s4.dn%0d", f), s4_w[f], 50, s4_t[f], s4_r[f], 0);
    bus.trim_dn  = 2'b00;
    bus.trim_clr = 2'b01;
    run_frame("s4.clr2", 40, 50, -10, 0, 0);
    bus.trim_clr = 2'b00;
    run_frame("s4.back0", 40, 50, 0, 1, 0);
    run_frame("s4.back1", 45, 50, 0, 1, 0);
    run_frame("s4.mid_mode", 50, 50, 0, 0, 2);

    // Scenario 5: enable drops at count 20, current pulse completes
    run_frame("s5.drop", 50, 50, 0, 0, 1);
    run_frame("s5.off", 0, 0, 0, 0, 0);
    bus.enable = 1'b1;
    run_frame("s5.wait", 0, 0, 0, 0, 0);
    bus.trim_up = 2'b01;
    run_frame("s5.back", 50, 50, 0, 0, 0);
    bus.trim_up = 2'b00;

    // Scenario 6: async reset in the middle of a pulse
    waits = 0;
    @(negedge m_clock);
    while (bus.frame_start !== 1'b1 && waits < 300) begin
      waits++;
      @(negedge m_clock);
    end
    check("s6.fs_wait", waits, 0);
    check("s6.trim_pre", trim_of(0), 2);
    repeat (29) @(negedge m_clock);
    check("s6.pulse_pre", 32'(bus.pwm_out), 3);
    p_reset = 1'b0;
    #1;
    check("s6.pwm_rst", 32'(bus.pwm_out), 0);
    check("s6.fs_rst", 32'(bus.frame_start), 0);
    check("s6.trim_rst", 32'(bus.trim_val), 0);
    @(negedge m_clock);
    p_reset = 1'b1;
    run_frame("s6.r0", 0, 0, 0, 0, 0);
    run_frame("s6.r1", 50, 50, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
